// File: rtl/program_memory_controller.sv
// program_memory_controller: arbitrates instruction fetch requests from several consumers onto
// program memory read channels. Each channel runs its own FSM, and a shared round-robin pointer prevents starvation.
module program_memory_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);
    localparam int ID_BITS = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    typedef enum logic [1:0] {IDLE, READ_WAITING, RELAYING} state_t;
    state_t state [NUM_CHANNELS];
    logic [ID_BITS-1:0] id [NUM_CHANNELS];
    logic [ID_BITS-1:0] grant_id [NUM_CHANNELS];
    logic [ID_BITS-1:0] rr_ptr, next_ptr;
    logic [NUM_CONSUMERS-1:0] busy, taken;
    logic [NUM_CHANNELS-1:0] grant;
    logic any_grant;
    logic [ADDR_BITS-1:0] caddr [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] cdata [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] maddr [NUM_CHANNELS];
    logic [DATA_BITS-1:0] mdata [NUM_CHANNELS];

    function automatic logic [ID_BITS-1:0] wrap(input int v);
        return ID_BITS'(v >= NUM_CONSUMERS ? v - NUM_CONSUMERS : v);
    endfunction

    for (genvar k = 0; k < NUM_CONSUMERS; k++) begin : g_cons
        assign caddr[k] = consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
        assign consumer_read_data[k*DATA_BITS +: DATA_BITS] = cdata[k];
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        assign mdata[c] = mem_read_data[c*DATA_BITS +: DATA_BITS];
        assign mem_read_address[c*ADDR_BITS +: ADDR_BITS] = maddr[c];
    end

    // Downward scan lets the smallest offset from rr_ptr win; lower channels claim consumers first.
    always_comb begin
        taken = busy;
        next_ptr = rr_ptr;
        any_grant = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant[c] = 1'b0;
            grant_id[c] = '0;
            for (int i = NUM_CONSUMERS - 1; i >= 0; i--)
                if (state[c] == IDLE && consumer_read_valid[wrap(int'(rr_ptr) + i)]
                    && !taken[wrap(int'(rr_ptr) + i)]) begin
                    grant[c] = 1'b1;
                    grant_id[c] = wrap(int'(rr_ptr) + i);
                end
            if (grant[c]) begin
                taken[grant_id[c]] = 1'b1;
                next_ptr = wrap(int'(grant_id[c]) + 1);
                any_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            busy <= '0;
            consumer_read_ready <= '0;
            mem_read_valid <= '0;
            for (int k = 0; k < NUM_CONSUMERS; k++) cdata[k] <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                id[c] <= '0;
                maddr[c] <= '0;
            end
        end else begin
            if (any_grant) rr_ptr <= next_ptr;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (grant[c]) begin
                        mem_read_valid[c] <= 1'b1;
                        maddr[c] <= caddr[grant_id[c]];
                        busy[grant_id[c]] <= 1'b1;
                        id[c] <= grant_id[c];
                        state[c] <= READ_WAITING;
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c] <= 1'b0;
                        consumer_read_ready[id[c]] <= 1'b1;
                        cdata[id[c]] <= mdata[c];
                        state[c] <= RELAYING;
                    end
                    RELAYING: if (!consumer_read_valid[id[c]]) begin
                        consumer_read_ready[id[c]] <= 1'b0;
                        busy[id[c]] <= 1'b0;
                        state[c] <= IDLE;
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_memory_controller.sv
// tb_program_memory_controller: per-cycle vector table (1ch/2cons), directed dual-channel sequence,
// and a randomized 3-consumer run checked against a transaction-level round-robin model.
module tb_program_memory_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // Instance p: 2 consumers, 1 channel
    logic p_rst = 1'b1, p_r = 1'b0, p_mv;
    logic [1:0] p_v = '0, p_cr;
    logic [15:0] p_a = '0, p_d = '0;
    logic [31:0] p_cd;
    logic [7:0] p_ma;
    program_memory_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .NUM_CHANNELS(1)) u_p (
        .clk(clk), .reset(p_rst),
        .consumer_read_valid(p_v), .consumer_read_address(p_a),
        .consumer_read_ready(p_cr), .consumer_read_data(p_cd),
        .mem_read_valid(p_mv), .mem_read_address(p_ma),
        .mem_read_ready(p_r), .mem_read_data(p_d)
    );

    // Instance q: 2 consumers, 2 channels
    logic q_rst = 1'b1;
    logic [1:0] q_v = '0, q_cr, q_mv, q_r = '0;
    logic [15:0] q_a = '0, q_ma;
    logic [31:0] q_cd, q_d = '0;
    program_memory_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .NUM_CHANNELS(2)) u_q (
        .clk(clk), .reset(q_rst),
        .consumer_read_valid(q_v), .consumer_read_address(q_a),
        .consumer_read_ready(q_cr), .consumer_read_data(q_cd),
        .mem_read_valid(q_mv), .mem_read_address(q_ma),
        .mem_read_ready(q_r), .mem_read_data(q_d)
    );

    // Instance r: 3 consumers, 1 channel
    logic r_rst = 1'b1, r_mr = 1'b0, r_mv;
    logic [2:0] r_v = '0, r_cr;
    logic [23:0] r_a = '0;
    logic [47:0] r_cd;
    logic [7:0] r_ma;
    logic [15:0] r_md = '0;
    program_memory_controller #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(3), .NUM_CHANNELS(1)) u_r (
        .clk(clk), .reset(r_rst),
        .consumer_read_valid(r_v), .consumer_read_address(r_a),
        .consumer_read_ready(r_cr), .consumer_read_data(r_cd),
        .mem_read_valid(r_mv), .mem_read_address(r_ma),
        .mem_read_ready(r_mr), .mem_read_data(r_md)
    );

    typedef struct {
        logic rst; logic [1:0] v; logic [7:0] a0, a1; logic r; logic [15:0] d;
        logic mv; logic [7:0] ma; logic [1:0] cr; logic [15:0] c0, c1;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1,
                                input logic r, input logic [15:0] d, input logic mv, input logic [7:0] ma,
                                input logic [1:0] cr, input logic [15:0] c0, input logic [15:0] c1);
        vec_t x;
        x.rst = rst; x.v = v; x.a0 = a0; x.a1 = a1; x.r = r; x.d = d;
        x.mv = mv; x.ma = ma; x.cr = cr; x.c0 = c0; x.c1 = c1;
        vecs.push_back(x);
    endfunction

    int rr, cur, pick, dly;
    int served [3];
    int waits [3];
    logic prev_mv;
    logic [2:0] prev_cr;
    logic [7:0] exp_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //   rst v      a0     a1     r  d         | mv ma     cr     c0        c1
        add(1, 2'b00, 8'h00, 8'h00, 0, 16'h0000,  0, 8'h00, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b01, 8'h05, 8'h00, 0, 16'h0000,  1, 8'h05, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b01, 8'h05, 8'h00, 1, 16'hA1B2,  0, 8'h05, 2'b01, 16'hA1B2, 16'h0000);
        add(0, 2'b01, 8'h05, 8'h00, 1, 16'hFFFF,  0, 8'h05, 2'b01, 16'hA1B2, 16'h0000);
        add(0, 2'b00, 8'h05, 8'h00, 0, 16'h0000,  0, 8'h05, 2'b00, 16'hA1B2, 16'h0000);
        add(1, 2'b00, 8'h00, 8'h00, 0, 16'h0000,  0, 8'h00, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b11, 8'h10, 8'h20, 0, 16'h0000,  1, 8'h10, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b11, 8'h10, 8'h20, 1, 16'h1234,  0, 8'h10, 2'b01, 16'h1234, 16'h0000);
        add(0, 2'b10, 8'h10, 8'h20, 0, 16'h0000,  0, 8'h10, 2'b00, 16'h1234, 16'h0000);
        add(0, 2'b11, 8'h10, 8'h20, 0, 16'h0000,  1, 8'h20, 2'b00, 16'h1234, 16'h0000);
        add(0, 2'b11, 8'h10, 8'h20, 1, 16'h5678,  0, 8'h20, 2'b10, 16'h1234, 16'h5678);
        add(0, 2'b01, 8'h10, 8'h20, 0, 16'h0000,  0, 8'h20, 2'b00, 16'h1234, 16'h5678);
        add(0, 2'b11, 8'h30, 8'h40, 0, 16'h0000,  1, 8'h30, 2'b00, 16'h1234, 16'h5678);
        add(0, 2'b11, 8'h30, 8'h40, 1, 16'h9ABC,  0, 8'h30, 2'b01, 16'h9ABC, 16'h5678);
        add(0, 2'b10, 8'h30, 8'h40, 0, 16'h0000,  0, 8'h30, 2'b00, 16'h9ABC, 16'h5678);
        add(0, 2'b11, 8'h30, 8'h40, 0, 16'h0000,  1, 8'h40, 2'b00, 16'h9ABC, 16'h5678);
        add(0, 2'b11, 8'h30, 8'h40, 1, 16'hDEF0,  0, 8'h40, 2'b10, 16'h9ABC, 16'hDEF0);
        add(0, 2'b01, 8'h30, 8'h40, 0, 16'h0000,  0, 8'h40, 2'b00, 16'h9ABC, 16'hDEF0);
        add(0, 2'b01, 8'h30, 8'h40, 0, 16'h0000,  1, 8'h30, 2'b00, 16'h9ABC, 16'hDEF0);
        for (int s = 0; s < 7; s++)
            add(0, 2'b01, 8'h77, 8'h40, 0, 16'h0000,  1, 8'h30, 2'b00, 16'h9ABC, 16'hDEF0);
        add(0, 2'b01, 8'h77, 8'h40, 1, 16'h0F0F,  0, 8'h30, 2'b01, 16'h0F0F, 16'hDEF0);
        add(0, 2'b00, 8'h77, 8'h40, 0, 16'h0000,  0, 8'h30, 2'b00, 16'h0F0F, 16'hDEF0);
        add(0, 2'b01, 8'h55, 8'h40, 0, 16'h0000,  1, 8'h55, 2'b00, 16'h0F0F, 16'hDEF0);
        add(1, 2'b01, 8'h55, 8'h40, 0, 16'h0000,  0, 8'h00, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b00, 8'h55, 8'h40, 1, 16'hBAD0,  0, 8'h00, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b01, 8'h66, 8'h40, 0, 16'h0000,  1, 8'h66, 2'b00, 16'h0000, 16'h0000);
        add(0, 2'b01, 8'h66, 8'h40, 1, 16'hC0DE,  0, 8'h66, 2'b01, 16'hC0DE, 16'h0000);
        add(0, 2'b00, 8'h66, 8'h40, 0, 16'h0000,  0, 8'h66, 2'b00, 16'hC0DE, 16'h0000);
        add(0, 2'b01, 8'h12, 8'h40, 0, 16'h0000,  1, 8'h12, 2'b00, 16'hC0DE, 16'h0000);
        add(0, 2'b00, 8'h12, 8'h40, 0, 16'h0000,  1, 8'h12, 2'b00, 16'hC0DE, 16'h0000);
        add(0, 2'b00, 8'h12, 8'h40, 1, 16'h4444,  0, 8'h12, 2'b01, 16'h4444, 16'h0000);
        add(0, 2'b00, 8'h12, 8'h40, 0, 16'h0000,  0, 8'h12, 2'b00, 16'h4444, 16'h0000);
        foreach (vecs[i]) begin
            p_rst = vecs[i].rst; p_v = vecs[i].v; p_a = {vecs[i].a1, vecs[i].a0};
            p_r = vecs[i].r; p_d = vecs[i].d;
            @(posedge clk); #1;
            check($sformatf("vec%0d {mv,ma,cr,cd1,cd0}", i), {p_mv, p_ma, p_cr, p_cd},
                  {vecs[i].mv, vecs[i].ma, vecs[i].cr, vecs[i].c1, vecs[i].c0});
        end

        q_rst = 1'b0;
        check("dual_reset", {q_mv, q_ma, q_cr, q_cd}, '0);
        q_v = 2'b11; q_a = {8'h20, 8'h10};
        @(posedge clk); #1;
        check("dual_grant {mv,ma}", {q_mv, q_ma}, {2'b11, 16'h2010});
        q_r = 2'b10; q_d = {16'h2222, 16'h0000};
        @(posedge clk); #1;
        check("dual_ch1_first {mv,cr,cd}", {q_mv, q_cr, q_cd}, {2'b01, 2'b10, 32'h2222_0000});
        q_r = 2'b01; q_d = {16'h0000, 16'h1111};
        @(posedge clk); #1;
        check("dual_ch0 {mv,cr,cd}", {q_mv, q_cr, q_cd}, {2'b00, 2'b11, 32'h2222_1111});
        q_r = 2'b00; q_v = 2'b00;
        @(posedge clk); #1;
        check("dual_release", q_cr, 2'b00);
        q_v = 2'b10; q_a = {8'h33, 8'h00};
        @(posedge clk); #1;
        check("cross_grant {mv,ma0}", {q_mv, q_ma[7:0]}, {2'b01, 8'h33});
        q_r = 2'b01; q_d = {16'h0000, 16'h3333};
        @(posedge clk); #1;
        check("cross_data {cr,cd}", {q_cr, q_cd}, {2'b10, 32'h3333_1111});
        q_r = 2'b00; q_v = 2'b00;
        @(posedge clk); #1;
        check("cross_release", q_cr, 2'b00);

        rr = 0; cur = -1; dly = 0; prev_mv = 1'b0; prev_cr = '0;
        for (int k = 0; k < 3; k++) begin served[k] = 0; waits[k] = 0; end
        @(negedge clk);
        r_rst = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (r_mv && !prev_mv) begin
                pick = -1;
                for (int i = 2; i >= 0; i--) if (r_v[(rr + i) % 3]) pick = (rr + i) % 3;
                exp_addr = '0;
                if (pick >= 0) exp_addr = r_a[pick*8 +: 8];
                check("rand_grant {found,addr}", {pick >= 0, r_ma}, {1'b1, exp_addr});
                if (pick >= 0) begin
                    check($sformatf("rand_wait%0d", pick), waits[pick] <= 2, 1'b1);
                    waits[pick] = 0;
                    for (int j = 0; j < 3; j++) if (j != pick && r_v[j]) waits[j]++;
                    cur = pick;
                    rr = (pick + 1) % 3;
                end
            end
            for (int k = 0; k < 3; k++)
                if (r_cr[k] && !prev_cr[k]) begin
                    check($sformatf("rand_resp%0d {owner,data}", k), {k == cur, r_cd[k*16 +: 16]},
                          {1'b1, mem_word(r_a[k*8 +: 8])});
                    served[k]++;
                end
            for (int k = 0; k < 3; k++)
                if (r_cr[k]) r_v[k] = 1'b0;
                else if (!r_v[k] && $urandom_range(3) != 0) begin
                    r_v[k] = 1'b1;
                    r_a[k*8 +: 8] = {k[1:0], 6'($urandom)};
                end
            if (r_mr) r_mr = 1'b0;
            else if (r_mv) begin
                if (dly == 0) begin
                    r_mr = 1'b1;
                    r_md = mem_word(r_ma);
                    dly = $urandom_range(3);
                end else dly--;
            end
            prev_mv = r_mv;
            prev_cr = r_cr;
        end
        for (int k = 0; k < 3; k++) check($sformatf("rand_served%0d", k), served[k] > 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
